bus_target_resp: RTL

- Target/responder end of the bus transaction protocol. The initiator raises req, waits for grant, then holds frame for the burst.
- The block arbitrates the single request and supplies the read burst: dbus_enb, per-beat ack, data, and data_last on the final beat.
- It flags time_out if the initiator abandons a granted slot.
- It sits on the target side of the bus, facing the existing initiator-side controller.

---
 rtl/bus_resp_pkg.sv | 23 ++
 rtl/bus_target_resp_timer.sv | 33 +++
 rtl/bus_target_resp.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_resp_pkg.sv
// Shared types, default sizing and helpers for the bus target responder.
package bus_resp_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_XFER,
      S_DONE
   } resp_state_e;

   localparam int DATA_W_DEF  = 8;
   localparam int SIZE_W_DEF  = 4;
   localparam int TMO_CYC_DEF = 8;

   // Bits needed to count 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/bus_target_resp_timer.sv
// resp_timer: loadable up-counter with clear, enable and a terminal-count flag.
module resp_timer #(
   parameter int WIDTH  = 3,
   parameter int TC_VAL = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] TC = WIDTH'(TC_VAL);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && !o_tc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == TC);

endmodule

// File: rtl/bus_target_resp.sv
// bus_target_resp: grants one initiator request and streams the read burst.
// Define BUS_TARGET_RESP_PARITY_EN to add data_par (even parity of data_out).
module bus_target_resp
   import bus_resp_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SIZE_W  = SIZE_W_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              frame,
   input  logic [SIZE_W-1:0] size,
   input  logic              dbusy_n,
   input  logic [DATA_W-1:0] data_in,
   output logic              grant,
   output logic              dbus_enb,
   output logic [DATA_W-1:0] data_out,
   output logic              ack,
   output logic              data_last,
   output logic              data_rd,
   output logic              time_out,
`ifdef BUS_TARGET_RESP_PARITY_EN
   output logic              busy,
   output logic              data_par
`else
   output logic              busy
`endif
);

   localparam int TMR_W = clog2(TMO_CYC);

   resp_state_e       r_state;
   logic [SIZE_W-1:0] r_remaining;
   logic              r_grant;
   logic              r_dbus_enb;
   logic [DATA_W-1:0] r_data_out;
   logic              r_ack;
   logic              r_data_last;
   logic              r_time_out;
   logic              r_busy;
   logic              w_tmr_tc;
   logic              w_beat;

   resp_timer #(
      .WIDTH  (TMR_W),
      .TC_VAL (TMO_CYC - 1)
   ) u_grant_timer (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (r_state != S_GRANT),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_en       (r_state == S_GRANT),
      .o_tc       (w_tmr_tc)
   );

   // A beat moves only while the frame is held and the initiator is ready.
   assign w_beat = (r_state == S_XFER) && frame && dbusy_n && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_grant     <= 1'b0;
         r_dbus_enb  <= 1'b0;
         r_data_out  <= '0;
         r_ack       <= 1'b0;
         r_data_last <= 1'b0;
         r_time_out  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each cycle; branches only raise them.
         r_ack       <= 1'b0;
         r_data_last <= 1'b0;
         r_time_out  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_state <= S_GRANT;
                  r_grant <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_GRANT: begin
               if (frame) begin
                  r_remaining <= size;
                  r_state     <= S_XFER;
                  r_grant     <= 1'b0;
                  r_dbus_enb  <= 1'b1;
               end else if (w_tmr_tc) begin
                  r_time_out <= 1'b1;
                  r_grant    <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_XFER: begin
               if (!frame) begin
                  r_dbus_enb <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (dbusy_n) begin
                  r_data_out <= data_in;
                  r_ack      <= 1'b1;
                  if (r_remaining == '0) begin
                     r_data_last <= 1'b1;
                     r_dbus_enb  <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_remaining <= r_remaining - 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef BUS_TARGET_RESP_PARITY_EN
   logic r_data_par;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_par <= 1'b0;
      end else if (w_beat) begin
         r_data_par <= ^data_in;
      end
   end

   assign data_par = r_data_par;
`endif

   assign grant     = r_grant;
   assign dbus_enb  = r_dbus_enb;
   assign data_out  = r_data_out;
   assign ack       = r_ack;
   assign data_last = r_data_last;
   assign data_rd   = w_beat;
   assign time_out  = r_time_out;
   assign busy      = r_busy;

endmodule
